// File: rtl/ex_pkg.sv
// ex_pkg: shared constants for the execute/write-back stage.
//   - OP_* : 3-bit opcodes presented on in_op
//   - ex_state_e : stage FSM encodings (ST_IDLE, ST_MUL)
//   - SAT_MAX / SAT_MIN : signed clamp values used when EX_SAT_EN is defined
package ex_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MAC  = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_e;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/mac_iter.sv
// mac_iter: iterative unsigned multiply-accumulate, result = low 32 bits of a*b+c.
// Retires MUL_BITS bits of a per cycle (LSB first), MUL_STEPS = 32/MUL_BITS cycles.
// Ports:
//   clk    in   clock (state updates on negedge, same edge as the register file)
//   reset  in   synchronous active-high reset, aborts any iteration in flight
//   start  in   load a/b/c and begin iterating (ignored while clear-down by reset)
//   a,b,c  in   32-bit operands, sampled on start
//   done   out  high during the final iteration cycle
//   result out  a*b+c, valid while done is high
module mac_iter #(
  parameter int MUL_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        done,
  output logic [31:0] result
);

  localparam int MUL_STEPS = 32 / MUL_BITS;
  localparam int CNT_W     = $clog2(MUL_STEPS);

  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic [31:0]      partial;

  // a is shifted right and b left each step, so the current slice is always
  // a_q[MUL_BITS-1:0] and b_q already carries the matching weight.
  assign partial = 32'(a_q[MUL_BITS-1:0]) * b_q;

  // The last slice is folded in combinationally so the write can happen on
  // the same edge that ends the iteration.
  assign done   = run_q && (cnt_q == '0);
  assign result = acc_q + partial;

  always_ff @(negedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      a_q   <= a;
      b_q   <= b;
      acc_q <= c;
      cnt_q <= CNT_W'(MUL_STEPS - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      a_q   <= a_q >> MUL_BITS;
      b_q   <= b_q << MUL_BITS;
      acc_q <= acc_q + partial;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute/write-back stage behind the 8x32b 3-read-port register file.
// Single-cycle ALU ops write one cycle after acceptance; MAC iterates in mac_iter
// and writes MUL_STEPS cycles after acceptance.
// Optional feature macro: EX_SAT_EN (signed saturating ADD/SUB plus the ovf port).
// Handshake: an op is accepted on the negedge where in_valid && in_ready; in_ready
//   is high exactly when the FSM is idle, and inputs are ignored otherwise.
// Ports:
//   clk, reset           clock (negedge active), synchronous active-high reset
//   in_valid / in_ready  upstream handshake
//   in_op, in_a/b/c      opcode and operands (RD1/RD2/RD3)
//   in_dest              destination register index
//   regWrite, ds1, wData register-file write port (one-cycle strobe)
//   busy                 high while the MAC iterates
//   ovf                  EX_SAT_EN only: pulses with the write that was clamped
module ex_wb_stage
  import ex_pkg::*;
#(
  parameter int MUL_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  input  logic [2:0]  in_dest,
  output logic        regWrite,
  output logic [2:0]  ds1,
  output logic [31:0] wData,
`ifdef EX_SAT_EN
  output logic        ovf,
`endif
  output logic        busy
);

  ex_state_e   state_q;
  logic        reg_write_q;
  logic [2:0]  ds1_q;
  logic [31:0] wdata_q;
  logic [2:0]  dest_q;
  logic        accept;
  logic        mac_start;
  logic        mac_done;
  logic [31:0] mac_result;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] alu_res;
`ifdef EX_SAT_EN
  logic        add_ovf;
  logic        sub_ovf;
  logic        alu_ovf;
  logic        ovf_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_MUL);
  assign accept    = in_valid && in_ready;
  assign mac_start = accept && (in_op == OP_MAC);

  assign regWrite = reg_write_q;
  assign ds1      = ds1_q;
  assign wData    = wdata_q;

  assign sum  = in_a + in_b;
  assign diff = in_a - in_b;

`ifdef EX_SAT_EN
  // Signed overflow: result sign disagrees with what the operand signs allow.
  assign add_ovf = (in_a[31] == in_b[31]) && (sum[31]  != in_a[31]);
  assign sub_ovf = (in_a[31] != in_b[31]) && (diff[31] != in_a[31]);
  assign ovf     = ovf_q;
`endif

  always_comb begin
    alu_res = in_c;
`ifdef EX_SAT_EN
    alu_ovf = 1'b0;
`endif
    case (in_op)
`ifdef EX_SAT_EN
      // On overflow the sign of a tells which rail was crossed.
      OP_ADD: begin
        alu_res = add_ovf ? (in_a[31] ? SAT_MIN : SAT_MAX) : sum;
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = sub_ovf ? (in_a[31] ? SAT_MIN : SAT_MAX) : diff;
        alu_ovf = sub_ovf;
      end
`else
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
`endif
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      default: alu_res = in_c;
    endcase
  end

  mac_iter #(
    .MUL_BITS(MUL_BITS)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .start  (mac_start),
    .a      (in_a),
    .b      (in_b),
    .c      (in_c),
    .done   (mac_done),
    .result (mac_result)
  );

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      reg_write_q <= 1'b0;
      ds1_q       <= '0;
      wdata_q     <= '0;
      dest_q      <= '0;
`ifdef EX_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      reg_write_q <= 1'b0;
`ifdef EX_SAT_EN
      ovf_q       <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (in_op == OP_MAC) begin
              state_q <= ST_MUL;
              dest_q  <= in_dest;
            end else if (in_op != OP_NOP) begin
              reg_write_q <= 1'b1;
              ds1_q       <= in_dest;
              wdata_q     <= alu_res;
`ifdef EX_SAT_EN
              ovf_q       <= alu_ovf;
`endif
            end
          end
        end
        ST_MUL: begin
          if (mac_done) begin
            state_q     <= ST_IDLE;
            reg_write_q <= 1'b1;
            ds1_q       <= dest_q;
            wdata_q     <= mac_result;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Testbench for ex_wb_stage: directed ops, expected writes queued at acceptance
// and checked by an independent monitor on the opposite clock edge.
module tb_ex_wb_stage;

  localparam int W = 36; // {ovf, ds1[2:0], wData[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_c;
  logic [2:0]  in_dest;
  logic        regWrite;
  logic [2:0]  ds1;
  logic [31:0] wData;
  logic        busy;
  logic        act_ovf;
`ifdef EX_SAT_EN
  logic        ovf;
  assign act_ovf = ovf;
`else
  assign act_ovf = 1'b0;
`endif

  ex_wb_stage dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_c     (in_c),
    .in_dest  (in_dest),
    .regWrite (regWrite),
    .ds1      (ds1),
    .wData    (wData),
`ifdef EX_SAT_EN
    .ovf      (ovf),
`endif
    .busy     (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(negedge clk) cyc++;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  always @(posedge clk) begin
    if (regWrite) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got ds1=%0d wData=%h, required no write", ds1, wData);
      end else begin
        logic [W-1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({act_ovf, ds1, wData} !== e || cyc != ec) begin
          failures++;
          $display("FAIL write: got ovf/ds1/wData=%h cycle=%0d, required %h cycle=%0d",
                   {act_ovf, ds1, wData}, cyc, e, ec);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present an op, wait (bounded) for in_ready, let it be accepted, and queue
  // the expected write together with the cycle it must appear in.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [2:0] dest, input logic exp_wr,
                       input logic [31:0] exp_data, input logic exp_ovf, input int lat,
                       output int waits);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_dest  = dest;
    waits    = 0;
    while (!in_ready && waits < 50) begin
      check("busy_while_not_ready", 32'(busy), 32'd1);
      waits++;
      @(posedge clk);
      #1;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    #1;
    if (exp_wr) begin
      exp_q.push_back({exp_ovf, dest, exp_data});
      exp_cyc_q.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_op    = 3'd0;
    in_a     = '0;
    in_b     = '0;
    in_c     = '0;
    in_dest  = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    // 1: reset state
    check("rst_regWrite", 32'(regWrite), 32'd0);
    check("rst_ds1",      32'(ds1),      32'd0);
    check("rst_wData",    wData,         32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    reset = 1'b0;
    idle(1);

    // 2: back-to-back ADD / SUB
    issue(3'd0, 32'd5, 32'd7, 32'd0, 3'd3, 1'b1, 32'd12,        1'b0, 0, w);
    issue(3'd1, 32'd5, 32'd7, 32'd0, 3'd4, 1'b1, 32'hFFFF_FFFE, 1'b0, 0, w);
    // remaining single-cycle ops, also back-to-back
    issue(3'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 3'd1, 1'b1, 32'h00F0_000F, 1'b0, 0, w);
    issue(3'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 3'd5, 1'b1, 32'hFFF0_0FFF, 1'b0, 0, w);
    issue(3'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 3'd6, 1'b1, 32'hFF00_0FF0, 1'b0, 0, w);
    issue(3'd6, 32'd1, 32'd2, 32'hDEAD_BEEF, 3'd7, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, w);
    idle(2);

    // 3: MAC 6*7+100, with the next op held valid throughout busy
    issue(3'd5, 32'd6, 32'd7, 32'd100, 3'd2, 1'b1, 32'd142, 1'b0, 8, w);
    issue(3'd0, 32'd10, 32'd20, 32'd0, 3'd7, 1'b1, 32'd30, 1'b0, 0, w);
    check("mac_not_ready_cycles", 32'(w), 32'd8);
    idle(3);

    // 4: MAC wrap, then NOP (no write, outputs hold)
    issue(3'd5, 32'hFFFF_FFFF, 32'd2, 32'd1, 3'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, 8, w);
    issue(3'd7, 32'd9, 32'd9, 32'd9, 3'd5, 1'b0, 32'd0, 1'b0, 0, w);
    idle(3);
    check("nop_ds1_hold",   32'(ds1), 32'd1);
    check("nop_wData_hold", wData,    32'hFFFF_FFFF);

    // 5: reset in MAC cycle 4 aborts without a write
    issue(3'd5, 32'd3, 32'd4, 32'd5, 3'd6, 1'b0, 32'd0, 1'b0, 0, w);
    idle(3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_regWrite", 32'(regWrite), 32'd0);
    check("abort_ds1",      32'(ds1),      32'd0);
    check("abort_wData",    wData,         32'd0);
    idle(12);
    issue(3'd0, 32'd1, 32'd1, 32'd0, 3'd2, 1'b1, 32'd2, 1'b0, 0, w);
    idle(2);

`ifdef EX_SAT_EN
    // 6: saturation
    issue(3'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 3'd3, 1'b1, 32'h7FFF_FFFF, 1'b1, 0, w);
    issue(3'd1, 32'h8000_0000, 32'd1, 32'd0, 3'd4, 1'b1, 32'h8000_0000, 1'b1, 0, w);
    issue(3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 3'd5, 1'b1, 32'd0,         1'b0, 0, w);
    idle(2);
`endif

    idle(4);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
